cnn_sdiv_21s_7u: RTL
====================

CNN_SDIV_21S_7U -- requirements
Module: cnn_sdiv_21s_7u

Interface
REQ-001 SHALL have parameter DIVIDEND_W, default 21, meaning dividend width, signed two's complement.
REQ-002 SHALL have parameter DIVISOR_W, default 7, meaning divisor width, unsigned.
REQ-003 SHALL have parameter QUOT_W, default 14, meaning quotient width, signed, saturating.
REQ-004 SHALL have port ap_clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port ap_rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, meaning dividend/divisor are valid.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts an operand pair.
REQ-008 SHALL have port dividend, input, DIVIDEND_W, meaning signed numerator.
REQ-009 SHALL have port divisor, input, DIVISOR_W, meaning unsigned denominator.
REQ-010 SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-011 SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-012 SHALL have port quot, output, QUOT_W, meaning signed quotient, truncated toward zero and saturated.
REQ-013 SHALL have port rem, output, DIVISOR_W+1, meaning signed remainder carrying the dividend's sign.
REQ-014 SHALL have port ovf, output, 1, meaning the quotient was saturated.
REQ-015 SHALL have port dz, output, 1, meaning the divisor was zero.

Function
REQ-016 SHALL implement FSM IDLE -> CALC -> FIX -> DONE -> IDLE; in_ready = 1 only in IDLE, out_valid = 1 only in DONE.
REQ-017 SHALL, on in_valid && in_ready, latch |dividend|, divisor and the dividend sign; nonzero divisor -> CALC, zero divisor -> FIX.
REQ-018 SHALL, in CALC, perform one restoring-division bit per cycle on the 21-bit magnitude (shift, trial subtract, restore) for exactly DIVIDEND_W cycles using an iteration counter, then enter FIX.
REQ-019 SHALL, in FIX, negate quotient and remainder when the dividend is negative, then saturate the quotient to [-8192, +8191]; ovf = 1 only when saturation changed the value (-8192 exact is not overflow).
REQ-020 SHALL, for a zero divisor, produce quot = +8191 (dividend >= 0) or -8192 (dividend < 0), rem = 0, dz = 1, ovf = 0.
REQ-021 SHALL, for a nonzero divisor, make out_valid rise 22 cycles after the accepting edge; for a zero divisor, 2 cycles after it.
REQ-022 SHALL hold quot, rem, ovf and dz stable while out_valid && !out_ready.
REQ-023 SHALL, on out_valid && out_ready, go to IDLE; in_ready asserts the following cycle, giving a one-cycle bubble and no overlap of results.
REQ-024 SHALL ignore in_valid outside IDLE and out_ready outside DONE.

Reset
REQ-025 SHALL, when ap_rst_n = 0, asynchronously force IDLE and set in_ready = 0 during reset; out_valid, quot, rem, ovf, dz and all internal registers = 0.
REQ-026 SHALL discard an in-flight operation on reset mid-CALC/FIX/DONE; in_ready = 1 on the first cycle after release.

Structure
REQ-027 SHALL place width constants and the FSM state encoding in shared package cnn_div_pkg.
REQ-028 SHALL factor the combinational shift/trial-subtract step into sub-module cnn_sdiv_21s_7u_step; sign fix-up and saturation stay in the top module.

Verification
REQ-029 SHALL cover: 1000 / 7 -> quot = 142, rem = 6, ovf = 0, dz = 0, out_valid 22 cycles after accept.
REQ-030 SHALL cover: -1000 / 7 -> quot = -142, rem = -6; and -8192 / 1 -> quot = -8192, ovf = 0.
REQ-031 SHALL cover: 1048575 / 3 -> quot = 8191, ovf = 1; and -1048576 / 1 -> quot = -8192, ovf = 1.
REQ-032 SHALL cover: -5 / 0 -> quot = -8192, rem = 0, dz = 1, out_valid 2 cycles after accept.
REQ-033 SHALL cover: out_ready held low 10 cycles in DONE -> outputs unchanged and in_ready = 0; then release -> in_ready = 1 the next cycle.
REQ-034 SHALL cover: ap_rst_n pulsed low at CALC iteration 10 -> all outputs 0 immediately; a new 100 / 9 after release -> quot = 11, rem = 1.

Source files
------------

// File: rtl/cnn_div_pkg.sv
// Shared constants and FSM encoding for the 21s/7u restoring divider.
// Widths here are the defaults; the top module may override them by parameter.
package cnn_div_pkg;

    localparam int DIV_DIVIDEND_W = 21;
    localparam int DIV_DIVISOR_W  = 7;
    localparam int DIV_QUOT_W     = 14;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/cnn_sdiv_21s_7u_step.sv
// One restoring-division step: shift in the next dividend bit, trial subtract, restore.
// Purely combinational; the caller owns all state.
module cnn_sdiv_21s_7u_step #(
    parameter int DIVISOR_W = 7
) (
    input  logic [DIVISOR_W-1:0] prem_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W-1:0] prem_o,
    output logic                 q_bit_o
);

    logic [DIVISOR_W:0] shifted;

    // Partial remainder is always below the divisor, so the result fits back in DIVISOR_W bits.
    always_comb begin
        shifted = {prem_i, bit_i};
        q_bit_o = (shifted >= {1'b0, divisor_i});
        prem_o  = q_bit_o ? DIVISOR_W'(shifted - {1'b0, divisor_i}) : shifted[DIVISOR_W-1:0];
    end

endmodule

// File: rtl/cnn_sdiv_21s_7u.sv
// Signed/unsigned divider with saturating quotient; 22-cycle result (2 for divide-by-zero).
// One operation in flight; result held until out_ready, then a one-cycle bubble before in_ready.
module cnn_sdiv_21s_7u
    import cnn_div_pkg::*;
#(
    parameter int DIVIDEND_W = DIV_DIVIDEND_W,
    parameter int DIVISOR_W  = DIV_DIVISOR_W,
    parameter int QUOT_W     = DIV_QUOT_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     quot,
    output logic [DIVISOR_W:0]    rem,
    output logic                  ovf,
    output logic                  dz
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);
    localparam int REM_W = DIVISOR_W + 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DIVIDEND_W - 1);
    localparam logic [DIVIDEND_W-1:0] POS_LIM  = DIVIDEND_W'((1 << (QUOT_W - 1)) - 1);
    localparam logic [DIVIDEND_W-1:0] NEG_LIM  = DIVIDEND_W'(1 << (QUOT_W - 1));
    localparam logic [QUOT_W-1:0]     Q_MAX    = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0]     Q_MIN    = {1'b1, {(QUOT_W-1){1'b0}}};

    div_state_e             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DIVIDEND_W-1:0]  qm_q;
    logic [DIVISOR_W-1:0]   prem_q;
    logic [DIVISOR_W-1:0]   dvs_q;
    logic                   neg_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [QUOT_W-1:0]      quot_q;
    logic [REM_W-1:0]       rem_q;
    logic                   ovf_q;
    logic                   dz_q;

    logic [DIVISOR_W-1:0]   prem_d;
    logic                   q_bit;
    logic [QUOT_W-1:0]      fix_quot;
    logic [REM_W-1:0]       fix_rem;
    logic                   fix_ovf;
    logic                   div_zero;

    assign div_zero = (dvs_q == '0);

    // qm_q starts as |dividend| and, bit by bit, is replaced by the quotient magnitude.
    cnn_sdiv_21s_7u_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .prem_i    (prem_q),
        .bit_i     (qm_q[DIVIDEND_W-1]),
        .divisor_i (dvs_q),
        .prem_o    (prem_d),
        .q_bit_o   (q_bit)
    );

    always_comb begin
        fix_quot = '0;
        fix_rem  = '0;
        fix_ovf  = 1'b0;
        if (div_zero) begin
            fix_quot = neg_q ? Q_MIN : Q_MAX;
        end else if (neg_q) begin
            fix_rem = -{1'b0, prem_q};
            if (qm_q > NEG_LIM) begin
                fix_quot = Q_MIN;
                fix_ovf  = 1'b1;
            end else begin
                fix_quot = -qm_q[QUOT_W-1:0];
            end
        end else begin
            fix_rem = {1'b0, prem_q};
            if (qm_q > POS_LIM) begin
                fix_quot = Q_MAX;
                fix_ovf  = 1'b1;
            end else begin
                fix_quot = qm_q[QUOT_W-1:0];
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            qm_q        <= '0;
            prem_q      <= '0;
            dvs_q       <= '0;
            neg_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        qm_q       <= dividend[DIVIDEND_W-1] ? -dividend : dividend;
                        dvs_q      <= divisor;
                        neg_q      <= dividend[DIVIDEND_W-1];
                        prem_q     <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= (divisor == '0) ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    qm_q   <= {qm_q[DIVIDEND_W-2:0], q_bit};
                    prem_q <= prem_d;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_FIX: begin
                    // Divide-by-zero dwells one extra cycle here to give it a fixed 2-cycle latency.
                    if (div_zero && cnt_q == '0) begin
                        cnt_q <= CNT_W'(1);
                    end else begin
                        cnt_q       <= '0;
                        quot_q      <= fix_quot;
                        rem_q       <= fix_rem;
                        ovf_q       <= fix_ovf;
                        dz_q        <= div_zero;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quot      = quot_q;
    assign rem       = rem_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;

endmodule
